mlp_layer_sequencer: RTL and testbench

- Top-level sequencer for the bgn_inference layer pipelines (LAYER1, LAYER2, ...).
- Accepts one inference request on an ap_ctrl_hs-style handshake and launches each non-skipped layer engine in order.
- Each layer must report done before the next layer starts; a watchdog aborts a hung layer.
- Sits between the host control interface and the per-layer pipeline ap_start/ap_ready/ap_done ports.

---
 rtl/mlp_seq_pkg.sv | 21 ++
 rtl/seq_sat_counter.sv | 18 +
 rtl/mlp_layer_sequencer.sv | 131 +++++++++++++
 tb/tb_mlp_layer_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mlp_seq_pkg.sv
// mlp_seq_pkg: shared FSM states and layer-selection helpers for the layer sequencer
package mlp_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int MAX_LAYERS = 64;
  localparam int MAX_LID_W = 6;
  typedef struct packed {
    logic                 valid;
    logic [MAX_LID_W-1:0] idx;
  } nxt_t;
  function automatic int lid_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // lowest unskipped layer at or above 'from', among the first n layers
  function automatic nxt_t next_unskipped(input logic [MAX_LAYERS-1:0] mask, input int from, input int n);
    nxt_t r;
    r = '0;
    for (int i = MAX_LAYERS - 1; i >= 0; i--)
      if (i >= from && i < n && !mask[i]) r = '{valid: 1'b1, idx: MAX_LID_W'(i)};
    return r;
  endfunction
endpackage

// File: rtl/seq_sat_counter.sv
// seq_sat_counter: clearable, enabled up-counter that sticks at all-ones
module seq_sat_counter #(
  parameter int W = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  // clear has priority over counting; stop at the maximum value
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i && !(&cnt_q)) cnt_q <= cnt_q + W'(1);
  assign cnt_o = cnt_q;
endmodule

// File: rtl/mlp_layer_sequencer.sv
// mlp_layer_sequencer: launches unskipped layer engines in order with a per-layer watchdog; MLP_SEQ_PROFILE_EN adds cycle counters
module mlp_layer_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int CNT_W = 32,
  parameter int TMO_W = 24,
  localparam int LID_W = lid_w(NUM_LAYERS)
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic                        ap_start_i,
  output logic                        ap_ready_o,
  output logic                        ap_done_o,
  output logic                        ap_idle_o,
  input  logic [NUM_LAYERS-1:0]       skip_mask_i,
  output logic [NUM_LAYERS-1:0]       layer_start_o,
  input  logic [NUM_LAYERS-1:0]       layer_ready_i,
  input  logic [NUM_LAYERS-1:0]       layer_done_i,
  output logic [LID_W-1:0]            cur_layer_o,
  input  logic [TMO_W-1:0]            timeout_cycles_i,
  output logic                        error_o,
  output logic [LID_W-1:0]            err_layer_o,
  input  logic                        err_clear_i,
  output logic [NUM_LAYERS*CNT_W-1:0] layer_cycles_o,
  output logic [CNT_W-1:0]            total_cycles_o
);
  state_t                  state_q, state_d;
  logic [LID_W-1:0]        idx_q, idx_d, cur_q, cur_d, errl_q, errl_d;
  logic [NUM_LAYERS-1:0]   mask_q, mask_d;
  logic                    pend_q, pend_d, error_q, error_d;
  logic [TMO_W-1:0]        wd;
  logic                    accept, launch, tmo_hit, unused_idx_hi;
  nxt_t                    first, after;

  assign first = next_unskipped(MAX_LAYERS'(skip_mask_i), 0, NUM_LAYERS);
  assign after = next_unskipped(MAX_LAYERS'(mask_q), int'(idx_q) + 1, NUM_LAYERS);
  assign unused_idx_hi = ^{first.idx, after.idx};
  assign accept = state_q == IDLE && ap_start_i;
  assign tmo_hit = |timeout_cycles_i && wd == timeout_cycles_i - TMO_W'(1);

  // next-state logic: accept, launch/advance layers, watchdog abort, done pulse
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cur_d = cur_q;
    mask_d = mask_q;
    pend_d = pend_q;
    launch = 1'b0;
    error_d = err_clear_i ? 1'b0 : error_q;
    errl_d = err_clear_i ? '0 : errl_q;
    case (state_q)
      IDLE:
        if (ap_start_i) begin
          mask_d = skip_mask_i;
          state_d = first.valid ? RUN : DONE;
          if (first.valid) begin
            idx_d = LID_W'(first.idx);
            cur_d = LID_W'(first.idx);
            pend_d = 1'b1;
            launch = 1'b1;
          end
        end
      RUN: begin
        if (layer_ready_i[idx_q]) pend_d = 1'b0;
        if (layer_done_i[idx_q]) begin
          state_d = after.valid ? RUN : DONE;
          pend_d = after.valid;
          launch = after.valid;
          if (after.valid) begin
            idx_d = LID_W'(after.idx);
            cur_d = LID_W'(after.idx);
          end
        end else if (tmo_hit) begin
          error_d = 1'b1;
          errl_d = idx_q;
          pend_d = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and control registers
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      state_q <= IDLE;
      idx_q <= '0;
      cur_q <= '0;
      mask_q <= '0;
      pend_q <= 1'b0;
      error_q <= 1'b0;
      errl_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cur_q <= cur_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
      error_q <= error_d;
      errl_q <= errl_d;
    end

  seq_sat_counter #(.W(TMO_W)) u_wd (
    .clock_i(clock_i), .reset_i(reset_i), .clr_i(launch), .en_i(state_q == RUN), .cnt_o(wd)
  );

  assign ap_ready_o = accept;
  assign ap_done_o = state_q == DONE;
  assign ap_idle_o = state_q == IDLE;
  assign layer_start_o = (state_q == RUN && pend_q) ? NUM_LAYERS'(1) << idx_q : '0;
  assign cur_layer_o = cur_q;
  assign error_o = error_q;
  assign err_layer_o = errl_q;

`ifdef MLP_SEQ_PROFILE_EN
  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_lc
    seq_sat_counter #(.W(CNT_W)) u_lc (
      .clock_i(clock_i), .reset_i(reset_i), .clr_i(accept),
      .en_i(state_q == RUN && idx_q == LID_W'(i)), .cnt_o(layer_cycles_o[i*CNT_W +: CNT_W])
    );
  end
  seq_sat_counter #(.W(CNT_W)) u_total (
    .clock_i(clock_i), .reset_i(reset_i), .clr_i(accept), .en_i(state_q != IDLE), .cnt_o(total_cycles_o)
  );
`else
  assign layer_cycles_o = '0;
  assign total_cycles_o = '0;
`endif
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb_mlp_layer_sequencer: timeline-model checking of the layer sequencer with random and directed runs
module tb_mlp_layer_sequencer;
  localparam int NL = 2, CW = 32, TW = 24, LW = 1;
  logic clock_i = 1'b0, reset_i = 1'b1, ap_start_i = 1'b0, err_clear_i = 1'b0;
  logic ap_ready_o, ap_done_o, ap_idle_o, error_o;
  logic [NL-1:0] skip_mask_i = '0, layer_ready_i = '0, layer_done_i = '0, layer_start_o;
  logic [LW-1:0] cur_layer_o, err_layer_o;
  logic [TW-1:0] timeout_cycles_i = '0;
  logic [NL*CW-1:0] layer_cycles_o;
  logic [CW-1:0] total_cycles_o;
  int checks = 0, errors = 0;
  bit err_e = 0;
  int errl_e = 0, cur_e = 0;

  mlp_layer_sequencer #(.NUM_LAYERS(NL), .CNT_W(CW), .TMO_W(TW)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .ap_start_i(ap_start_i), .ap_ready_o(ap_ready_o),
    .ap_done_o(ap_done_o), .ap_idle_o(ap_idle_o), .skip_mask_i(skip_mask_i),
    .layer_start_o(layer_start_o), .layer_ready_i(layer_ready_i), .layer_done_i(layer_done_i),
    .cur_layer_o(cur_layer_o), .timeout_cycles_i(timeout_cycles_i), .error_o(error_o),
    .err_layer_o(err_layer_o), .err_clear_i(err_clear_i), .layer_cycles_o(layer_cycles_o),
    .total_cycles_o(total_cycles_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // non-observed input bits get noise so the DUT must ignore them
  task automatic drive_noise();
    layer_ready_i = NL'($urandom);
    layer_done_i = NL'($urandom);
    err_clear_i = $urandom_range(0, 7) == 0;
    skip_mask_i = NL'($urandom);
  endtask

  task automatic chk_sticky(input string tag);
    chk({tag, "_err"}, error_o, err_e);
    chk({tag, "_errl"}, err_layer_o, errl_e);
    chk({tag, "_cur"}, cur_layer_o, cur_e);
  endtask

  task automatic idle(input int n, input bit clr);
    for (int k = 0; k < n; k++) begin
      ap_start_i = 1'b0;
      drive_noise();
      if (clr) err_clear_i = 1'b1;
      #1;
      chk("idle_idle", ap_idle_o, 1);
      chk("idle_ready", ap_ready_o, 0);
      chk("idle_done", ap_done_o, 0);
      chk("idle_start", layer_start_o, 0);
      chk_sticky("idle");
      if (err_clear_i) begin err_e = 0; errl_e = 0; end
      tick();
    end
  endtask

  // one request; d = done cycle (1-based within layer), r = ready offset from start
  task automatic run(input logic [NL-1:0] mask, input int d0, input int d1, input int r0, input int r1,
                     input int tmo, input bit hold, input int abort_at);
    int d[NL], r[NL], s[NL], e[NL];
    bit act[NL], tmd[NL];
    int nxt, big_e, j;
    bit stop, to_now;
    logic [NL-1:0] st_e;
    logic [NL*CW-1:0] lc_e;
    d[0] = d0; d[1] = d1; r[0] = r0; r[1] = r1;
    nxt = 1; stop = 0;
    for (int i = 0; i < NL; i++) begin
      act[i] = !mask[i] && !stop;
      tmd[i] = act[i] && tmo != 0 && d[i] > tmo;
      s[i] = nxt;
      e[i] = nxt + (tmd[i] ? tmo : d[i]) - 1;
      if (act[i]) nxt = e[i] + 1;
      if (tmd[i]) stop = 1;
    end
    big_e = nxt;
    timeout_cycles_i = TW'(tmo);
    for (int t = 0; t <= big_e; t++) begin
      drive_noise();
      ap_start_i = t == 0 || hold;
      if (t == 0) skip_mask_i = mask;
      j = -1;
      for (int i = 0; i < NL; i++) if (act[i] && t >= s[i] && t <= e[i]) j = i;
      if (j >= 0) begin
        layer_ready_i[j] = t == s[j] + r[j];
        layer_done_i[j] = t == s[j] + d[j] - 1;
      end
      if (t == abort_at) begin
        reset_i = 1'b1;
        #1;
        chk("rst_mid_start", layer_start_o, 0);
        chk("rst_mid_idle", ap_idle_o, 1);
        chk("rst_mid_err", error_o, 0);
        chk("rst_mid_done", ap_done_o, 0);
        chk("rst_mid_cur", cur_layer_o, 0);
        chk("rst_mid_tot", total_cycles_o, 0);
        ap_start_i = 1'b0;
        tick();
        reset_i = 1'b0;
        err_e = 0; errl_e = 0; cur_e = 0;
        return;
      end
      #1;
      st_e = (j >= 0 && t <= s[j] + r[j]) ? NL'(1) << j : '0;
      if (j >= 0) cur_e = j;
      chk("ap_ready", ap_ready_o, t == 0);
      chk("ap_idle", ap_idle_o, t == 0);
      chk("ap_done", ap_done_o, t == big_e);
      chk("layer_start", layer_start_o, st_e);
      chk_sticky("run");
      to_now = j >= 0 && tmd[j] && t == e[j];
      if (to_now) begin err_e = 1; errl_e = j; end
      else if (err_clear_i) begin err_e = 0; errl_e = 0; end
      tick();
    end
    ap_start_i = 1'b0;
    err_clear_i = 1'b0;
    #1;
    lc_e = '0;
`ifdef MLP_SEQ_PROFILE_EN
    for (int i = 0; i < NL; i++) if (act[i]) lc_e[i*CW +: CW] = CW'(e[i] - s[i] + 1);
    chk("total_cycles", total_cycles_o, CW'(big_e));
`else
    chk("total_cycles", total_cycles_o, 0);
`endif
    chk("layer_cycles", layer_cycles_o, lc_e);
    chk("post_idle", ap_idle_o, 1);
    chk_sticky("post");
  endtask

  initial begin
    int d0, d1;
    repeat (2) @(posedge clock_i);
    #1;
    chk("rst_idle", ap_idle_o, 1);
    chk("rst_done", ap_done_o, 0);
    chk("rst_start", layer_start_o, 0);
    chk("rst_err", error_o, 0);
    chk("rst_errl", err_layer_o, 0);
    chk("rst_cur", cur_layer_o, 0);
    chk("rst_lc", layer_cycles_o, 0);
    chk("rst_tot", total_cycles_o, 0);
    reset_i = 1'b0;
    idle(2, 0);
    run(2'b00, 10, 5, 1, 0, 0, 0, -1);
    idle(1, 0);
    run(2'b01, 3, 6, 0, 2, 0, 0, -1);
    idle(1, 0);
    run(2'b11, 3, 3, 0, 0, 0, 0, -1);
    idle(1, 0);
    run(2'b00, 1000, 5, 2, 0, 100, 0, -1);
    idle(1, 1);
    idle(2, 0);
    run(2'b00, 6, 3, 0, 0, 6, 0, -1);
    idle(1, 0);
    run(2'b10, 20, 3, 5, 0, 3, 0, -1);
    run(2'b00, 10, 5, 1, 1, 0, 0, 3);
    idle(2, 0);
    run(2'b00, 4, 4, 0, 0, 0, 0, -1);
    run(2'b00, 4, 4, 1, 0, 0, 1, -1);
    run(2'b00, 4, 4, 0, 3, 0, 1, -1);
    run(2'b00, 4, 4, 2, 1, 0, 1, -1);
    idle(1, 0);
    for (int k = 0; k < 40; k++) begin
      d0 = $urandom_range(1, 12);
      d1 = $urandom_range(1, 12);
      run(NL'($urandom), d0, d1, $urandom_range(0, d0 - 1), $urandom_range(0, d1 - 1),
          $urandom_range(0, 1) ? 0 : $urandom_range(1, 12), 1'($urandom), -1);
      idle($urandom_range(0, 2), $urandom_range(0, 3) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
